// File: rtl/sr165_reader.sv
// sr165_reader: periodically loads a 74HC165 chain, shifts WIDTH bits in MSB
// first and publishes a debounced switch image after two identical frames.
//
// state  | meaning
// -------+--------------------------------------------------------------
// LOAD   | loadPin low for two ticks, parallel inputs captured by the 165
// SHIFT  | two ticks per bit: low phase samples dataIn, high phase clocks
// DONE   | one tick: frame compared with previous, sw_data maybe updated
// GAP    | GAP_TICKS idle ticks before the next LOAD
module sr165_reader #(
    parameter int CLK_DIV   = 400,
    parameter int WIDTH     = 8,
    parameter int GAP_TICKS = 5
) (
    input  logic             clck,
    input  logic             rst,
    input  logic             dataIn,
    output logic             loadPin,
    output logic             clockPin,
    output logic [WIDTH-1:0] sw_data,
    output logic             frame_done,
    output logic             sw_changed
);

    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    localparam int BITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BITW-1:0] BIT_LAST = BITW'(WIDTH - 1);

    // tick_left holds both the LOAD length (2 ticks) and the GAP length.
    localparam int TLW = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TLW-1:0] LOAD_LAST = TLW'(1);
    localparam logic [TLW-1:0] GAP_LAST  = TLW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [DIVW-1:0]  div_cnt;
    logic             tick;
    logic [1:0]       state;
    logic             phase;
    logic [BITW-1:0]  bit_cnt;
    logic [TLW-1:0]   tick_left;
    logic [WIDTH-1:0] frame;
    logic [WIDTH-1:0] prev;
    logic             din_meta;
    logic             din_sync;

    assign tick = (div_cnt == DIV_LAST);

    // Tick generator: free-running 0..CLK_DIV-1 counter.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous serial data from the 165.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            din_meta <= 1'b0;
            din_sync <= 1'b0;
        end else begin
            din_meta <= dataIn;
            din_sync <= din_meta;
        end
    end

    // Frame sequencer; pin registers are set to the level of the state being entered.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            state      <= ST_LOAD;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            tick_left  <= LOAD_LAST;
            frame      <= '0;
            prev       <= '0;
            sw_data    <= '0;
            loadPin    <= 1'b1;
            clockPin   <= 1'b0;
            frame_done <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sw_changed <= 1'b0;
            if (tick) begin
                case (state)
                    ST_LOAD: begin
                        bit_cnt  <= '0;
                        clockPin <= 1'b0;
                        if (tick_left == '0) begin
                            state   <= ST_SHIFT;
                            phase   <= 1'b0;
                            loadPin <= 1'b1;
                        end else begin
                            tick_left <= tick_left - 1'b1;
                            loadPin   <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        if (!phase) begin
                            // Sample before the rising edge that shifts the next bit out.
                            frame    <= (frame << 1) | WIDTH'(din_sync);
                            phase    <= 1'b1;
                            clockPin <= 1'b1;
                        end else begin
                            phase    <= 1'b0;
                            clockPin <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        frame_done <= 1'b1;
                        prev       <= frame;
                        if ((frame == prev) && (frame != sw_data)) begin
                            sw_data    <= frame;
                            sw_changed <= 1'b1;
                        end
                        if (GAP_TICKS == 0) begin
                            state     <= ST_LOAD;
                            tick_left <= LOAD_LAST;
                            loadPin   <= 1'b0;
                        end else begin
                            state     <= ST_GAP;
                            tick_left <= GAP_LAST;
                        end
                    end
                    default: begin
                        if (tick_left == '0) begin
                            state     <= ST_LOAD;
                            tick_left <= LOAD_LAST;
                            loadPin   <= 1'b0;
                        end else begin
                            tick_left <= tick_left - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr165_reader.sv
// Bench for sr165_reader: an 8-bit and a 16-bit instance, each driven by a
// behavioural 74HC165 chain, checked frame by frame against a scoreboard.
module tb_sr165_reader;

    localparam int CD  = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, rst16;
    logic        din8, din16;
    logic        lp8, cp8, fd8, swc8;
    logic        lp16, cp16, fd16, swc16;
    logic [7:0]  sw8;
    logic [15:0] sw16;
    logic [7:0]  par8;
    logic [15:0] par16;
    logic [7:0]  sr8  = '0;
    logic [15:0] sr16 = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fd [2];
    int rel;

    typedef struct packed {
        logic [15:0] sw;
        logic        chg;
    } exp_t;
    exp_t sb [$];

    sr165_reader #(.CLK_DIV(CD), .WIDTH(8), .GAP_TICKS(GAP)) dut8 (
        .clck(clk), .rst(rst8), .dataIn(din8), .loadPin(lp8), .clockPin(cp8),
        .sw_data(sw8), .frame_done(fd8), .sw_changed(swc8)
    );

    sr165_reader #(.CLK_DIV(CD), .WIDTH(16), .GAP_TICKS(GAP)) dut16 (
        .clck(clk), .rst(rst16), .dataIn(din16), .loadPin(lp16), .clockPin(cp16),
        .sw_data(sw16), .frame_done(fd16), .sw_changed(swc16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 165 chains: parallel load while SH/LD low, shift on CLK rise.
    always @(negedge lp8 or posedge cp8) begin
        if (!lp8) sr8 <= par8;
        else      sr8 <= {sr8[6:0], 1'b0};
    end
    assign din8 = sr8[7];

    always @(negedge lp16 or posedge cp16) begin
        if (!lp16) sr16 <= par16;
        else       sr16 <= {sr16[14:0], 1'b0};
    end
    assign din16 = sr16[15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waveform monitor for the 8-bit instance.
    logic lp_q = 1'b1;
    logic cp_q = 1'b0;
    int   t_load = 0;
    int   k_rise = 0;
    int   nchg8  = 0;
    always @(negedge clk) begin
        if (!rst8) begin
            if (lp8 && !lp_q) begin
                t_load = cyc;
                k_rise = 0;
            end
            if (cp8 && !cp_q) begin
                check("clk_rise_offset", cyc - t_load, CD * (1 + 2 * k_rise));
                k_rise++;
            end
            if (fd8) check("clk_rise_count", k_rise, 8);
            if (swc8) begin
                nchg8++;
                check("changed_without_done", fd8, 1'b1);
            end
        end
        lp_q = lp8;
        cp_q = cp8;
    end

    task automatic run_frame(input int which, input logic [15:0] p, input logic [15:0] esw,
                             input logic echg, input int eper);
        exp_t  e;
        int    n;
        logic  fd;
        string d;
        d = (which == 0) ? "w8" : "w16";
        if (which == 0) par8 = p[7:0];
        else            par16 = p;
        sb.push_back('{sw: esw, chg: echg});
        n  = 0;
        fd = 1'b0;
        while (!fd && n < 3000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            fd = (which == 0) ? fd8 : fd16;
        end
        if (!fd) check({d, "_frame_timeout"}, fd, 1'b1);
        e = sb.pop_front();
        check({d, "_sw_data"}, (which == 0) ? {8'h00, sw8} : sw16, e.sw);
        check({d, "_sw_changed"}, (which == 0) ? swc8 : swc16, e.chg);
        check({d, "_frame_period"}, cyc - last_fd[which], eper);
        last_fd[which] = cyc;
        @(posedge clk);
        @(negedge clk);
        check({d, "_done_width"}, (which == 0) ? fd8 : fd16, 1'b0);
        check({d, "_changed_width"}, (which == 0) ? swc8 : swc16, 1'b0);
    endtask

    initial begin
        int n;
        rst8  = 1'b1;
        rst16 = 1'b1;
        par8  = 8'hA5;
        par16 = 16'h1234;
        repeat (3) @(negedge clk);
        check("rst_loadPin", lp8, 1'b1);
        check("rst_clockPin", cp8, 1'b0);
        check("rst_sw_data", sw8, 8'h00);
        check("rst_frame_done", fd8, 1'b0);
        check("rst_sw_changed", swc8, 1'b0);

        // Release: loadPin falls after cycle 4 and rises after cycle 8.
        rst8 = 1'b0;
        rel = cyc;
        last_fd[0] = rel;
        repeat (3) @(posedge clk);
        @(negedge clk) check("load_c3", lp8, 1'b1);
        @(posedge clk);
        @(negedge clk) check("load_c4", lp8, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) check("load_c7", lp8, 1'b0);
        @(posedge clk);
        @(negedge clk) check("load_c8", lp8, 1'b1);

        // Static input, first frame 19 ticks after release, then 21-tick frames.
        run_frame(0, 16'h00A5, 16'h0000, 1'b0, 19 * CD);
        run_frame(0, 16'h00A5, 16'h00A5, 1'b1, 21 * CD);
        run_frame(0, 16'h00A5, 16'h00A5, 1'b0, 21 * CD);

        // Single-frame glitch is not published.
        run_frame(0, 16'h005A, 16'h00A5, 1'b0, 21 * CD);
        run_frame(0, 16'h00A5, 16'h00A5, 1'b0, 21 * CD);
        run_frame(0, 16'h00A5, 16'h00A5, 1'b0, 21 * CD);

        // MSB-first bit order.
        run_frame(0, 16'h0080, 16'h00A5, 1'b0, 21 * CD);
        run_frame(0, 16'h0080, 16'h0080, 1'b1, 21 * CD);

        // Reset during the high phase of bit 4.
        par8 = 8'hC3;
        n = 0;
        while (lp8 && n < 200) begin @(negedge clk); n++; end
        while (!lp8 && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) check("wait_load_rise", lp8, 1'b1);
        repeat (9 * CD + 2) @(negedge clk);
        check("pre_rst_clockPin", cp8, 1'b1);
        rst8 = 1'b1;
        #1;
        check("mid_rst_loadPin", lp8, 1'b1);
        check("mid_rst_clockPin", cp8, 1'b0);
        check("mid_rst_sw_data", sw8, 8'h00);
        check("mid_rst_frame_done", fd8, 1'b0);
        check("mid_rst_sw_changed", swc8, 1'b0);
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        last_fd[0] = cyc;
        run_frame(0, 16'h00C3, 16'h0000, 1'b0, 19 * CD);
        run_frame(0, 16'h00C3, 16'h00C3, 1'b1, 21 * CD);

        // Two chained 165s.
        rst16 = 1'b0;
        last_fd[1] = cyc;
        run_frame(1, 16'h1234, 16'h0000, 1'b0, 35 * CD);
        run_frame(1, 16'h1234, 16'h1234, 1'b1, 37 * CD);

        check("sw_changed8_count", nchg8, 3);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
